// File: rtl/extra_slot_arbiter.sv
// extra_slot_arbiter: shares the extra memory slot (busCycle 2'b10) between the
// internal/external disk, sound and DMA requesters using round-robin with optional sound priority.
module extra_slot_arbiter #(
    parameter logic [21:0] DSK_INT_BASE = 22'h100000,
    parameter logic [21:0] DSK_EXT_BASE = 22'h200000,
    parameter logic [21:0] SND_BASE     = 22'h000000,
    parameter logic [21:0] DMA_BASE     = 22'h000000,
    parameter bit          SND_PRIO     = 1'b1
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        clk8_en_p,
    input  logic [1:0]  busCycle,
    input  logic [3:0]  req,
    input  logic [21:0] reqAddr0,
    input  logic [21:0] reqAddr1,
    input  logic [21:0] reqAddr2,
    input  logic [21:0] reqAddr3,
    input  logic        dmaWrite,
    output logic [3:0]  grant,
    output logic [3:0]  ack,
    output logic [21:0] memoryAddr,
    output logic        extraRomRead,
    output logic        extraRamRead,
    output logic        extraRamWrite
);

    logic        arb_now;
    logic        slot_end;

    logic [1:0]  ptr_q, ptr_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  ack_q, ack_d;
    logic [21:0] addr_q, addr_d;
    logic        dma_wr_q, dma_wr_d;

    logic        win_valid;
    logic [1:0]  win_idx;
    logic [21:0] win_addr;
    logic        rr_found;
    logic [1:0]  rr_idx;

    // Arbitration happens at the end of slot 01; the granted slot ends at the end of slot 10.
    assign arb_now  = clk8_en_p && (busCycle == 2'b01);
    assign slot_end = clk8_en_p && (busCycle == 2'b10);

    // Winner selection: sound override first, otherwise scan upward from ptr+1.
    always_comb begin
        win_valid = |req;
        win_idx   = ptr_q;
        rr_found  = 1'b0;
        rr_idx    = 2'b00;
        if (SND_PRIO && req[2]) begin
            win_idx = 2'd2;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                rr_idx = ptr_q + 2'(k);
                if (!rr_found && req[rr_idx]) begin
                    win_idx  = rr_idx;
                    rr_found = 1'b1;
                end
            end
        end
    end

    // Base offsets wrap modulo 2^22; the carry out is deliberately dropped.
    always_comb begin
        case (win_idx)
            2'd0:    win_addr = reqAddr0 + DSK_INT_BASE;
            2'd1:    win_addr = reqAddr1 + DSK_EXT_BASE;
            2'd2:    win_addr = reqAddr2 + SND_BASE;
            default: win_addr = reqAddr3 + DMA_BASE;
        endcase
    end

    always_comb begin
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        dma_wr_d = dma_wr_q;
        ack_d    = 4'b0000;
        if (arb_now) begin
            if (win_valid) begin
                grant_d  = 4'b0001 << win_idx;
                ptr_d    = win_idx;
                addr_d   = win_addr;
                dma_wr_d = dmaWrite;
            end else begin
                grant_d  = 4'b0000;
            end
        end else if (slot_end) begin
            // A committed grant always completes, even if its request has dropped.
            ack_d   = grant_q;
            grant_d = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            ptr_q    <= 2'b11;
            grant_q  <= 4'b0000;
            ack_q    <= 4'b0000;
            addr_q   <= 22'h000000;
            dma_wr_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            addr_q   <= addr_d;
            dma_wr_q <= dma_wr_d;
        end
    end

    assign grant         = grant_q;
    assign ack           = ack_q;
    assign memoryAddr    = addr_q;
    assign extraRomRead  = grant_q[0] | grant_q[1];
    assign extraRamRead  = grant_q[2] | (grant_q[3] & ~dma_wr_q);
    assign extraRamWrite = grant_q[3] & dma_wr_q;

endmodule
